// File: rtl/lbp_window_sequencer_pkg.sv
// Shared constants for the LBP window sequencer: FSM encodings, window byte
// layout and default image geometry.
package lbp_window_sequencer_pkg;

  typedef logic [7:0] pixel_t;

  localparam int IMG_W_DEF  = 8;
  localparam int IMG_H_DEF  = 8;

  localparam int WIN_BYTES  = 9;
  localparam int WIN_COLS   = 3;
  localparam int WIN_CENTRE = 4;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FILL  = 3'd1;
  localparam logic [2:0] ST_SHIFT = 3'd2;
  localparam logic [2:0] ST_CAPT  = 3'd3;
  localparam logic [2:0] ST_VALID = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  // Raster byte index of window row i, column j.
  function automatic logic [3:0] win_byte_idx(input logic [1:0] i, input logic [1:0] j);
    return 4'(i) * 4'd3 + 4'(j);
  endfunction

endpackage

// File: rtl/lbp_window_regs.sv
// 3x3 pixel window storage: per-byte load, left shift of columns, and the
// packed raster output (byte k at [8k+:8]).
module lbp_window_regs
  import lbp_window_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        i_rst,
  input  logic        i_load,
  input  logic [3:0]  i_load_idx,
  input  pixel_t      i_load_data,
  input  logic        i_shift,
  output logic [71:0] o_win
);

  pixel_t r_px [WIN_BYTES];

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      for (int k = 0; k < WIN_BYTES; k++) r_px[k] <= '0;
    end else begin
      if (i_shift) begin
        for (int r = 0; r < WIN_COLS; r++) begin
          r_px[r*WIN_COLS]     <= r_px[r*WIN_COLS + 1];
          r_px[r*WIN_COLS + 1] <= r_px[r*WIN_COLS + 2];
        end
      end
      if (i_load) r_px[i_load_idx] <= i_load_data;
    end
  end

  for (genvar k = 0; k < WIN_BYTES; k++) begin : g_pack
    assign o_win[8*k +: 8] = r_px[k];
  end

endmodule

// File: rtl/lbp_window_sequencer.sv
// Fetch sequencer for the LBP datapath: scans interior pixels, builds each
// 3x3 window from gray memory (reusing two columns per step) and hands it off.
module lbp_window_sequencer
  import lbp_window_sequencer_pkg::*;
#(
  parameter int IMG_W  = IMG_W_DEF,
  parameter int IMG_H  = IMG_H_DEF,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] gray_addr,
  output logic              gray_req,
  input  logic [7:0]        gray_data,
  output logic              win_valid,
  input  logic              win_ready,
  output logic [71:0]       win_data,
  output logic [ADDR_W-1:0] win_addr,
  output logic              finish
);

  localparam logic [ADDR_W-1:0] W_A      = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] COL_LAST = ADDR_W'(IMG_W - 2);
  localparam logic [ADDR_W-1:0] ROW_LAST = ADDR_W'(IMG_H - 2);
  localparam logic [ADDR_W-1:0] ONE_A    = ADDR_W'(1);

  logic [2:0]        r_state;
  logic [ADDR_W-1:0] r_row;
  logic [ADDR_W-1:0] r_col;
  logic [1:0]        r_i;
  logic [1:0]        r_j;
  logic              r_cap_vld;
  logic [3:0]        r_cap_k;
  logic [ADDR_W-1:0] r_addr_hold;
  logic [ADDR_W-1:0] r_win_addr;

  logic              w_issue;
  logic              w_shift;
  logic [ADDR_W-1:0] w_issue_addr;

  // SHIFT keeps r_j at 2 so the same address formula yields column col+1.
  assign w_issue      = (r_state == ST_FILL) || (r_state == ST_SHIFT);
  assign w_issue_addr = (r_row - ONE_A + ADDR_W'(r_i)) * W_A + (r_col - ONE_A + ADDR_W'(r_j));
  assign w_shift      = (r_state == ST_VALID) && win_ready && (r_col < COL_LAST);

  assign gray_req  = w_issue;
  assign gray_addr = w_issue ? w_issue_addr : r_addr_hold;
  assign win_valid = (r_state == ST_VALID);
  assign win_addr  = r_win_addr;
  assign finish    = (r_state == ST_DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_row       <= ONE_A;
      r_col       <= ONE_A;
      r_i         <= 2'd0;
      r_j         <= 2'd0;
      r_cap_vld   <= 1'b0;
      r_cap_k     <= 4'd0;
      r_addr_hold <= '0;
      r_win_addr  <= '0;
    end else begin
      // Capture pointer trails the issue pointer by the memory's one-cycle latency.
      r_cap_vld <= w_issue;
      if (w_issue) begin
        r_cap_k     <= win_byte_idx(r_i, r_j);
        r_addr_hold <= w_issue_addr;
      end
      case (r_state)
        ST_IDLE: begin
          r_i     <= 2'd0;
          r_j     <= 2'd0;
          r_state <= ST_FILL;
        end
        ST_FILL: begin
          if (r_j == 2'd2) begin
            r_j <= 2'd0;
            if (r_i == 2'd2) begin
              r_i     <= 2'd0;
              r_state <= ST_CAPT;
            end else begin
              r_i <= r_i + 2'd1;
            end
          end else begin
            r_j <= r_j + 2'd1;
          end
        end
        ST_SHIFT: begin
          if (r_i == 2'd2) r_state <= ST_CAPT;
          else             r_i     <= r_i + 2'd1;
        end
        ST_CAPT: begin
          r_win_addr <= r_row * W_A + r_col;
          r_state    <= ST_VALID;
        end
        ST_VALID: begin
          if (win_ready) begin
            r_i <= 2'd0;
            if (r_col < COL_LAST) begin
              r_col   <= r_col + ONE_A;
              r_j     <= 2'd2;
              r_state <= ST_SHIFT;
            end else if (r_row < ROW_LAST) begin
              r_col   <= ONE_A;
              r_row   <= r_row + ONE_A;
              r_j     <= 2'd0;
              r_state <= ST_FILL;
            end else begin
              r_state <= ST_DONE;
            end
          end
        end
        ST_DONE: r_state <= ST_DONE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  lbp_window_regs u_win (
    .clk         (clk),
    .i_rst       (reset),
    .i_load      (r_cap_vld),
    .i_load_idx  (r_cap_k),
    .i_load_data (gray_data),
    .i_shift     (w_shift),
    .o_win       (win_data)
  );

endmodule

// File: tb/tb_lbp_window_sequencer.sv
// Directed bench for lbp_window_sequencer with a synchronous gray memory
// model (pixel = address) and queue-based window/request scoreboards.
module tb_lbp_window_sequencer;

  localparam int W  = 8;
  localparam int H  = 8;
  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] gray_addr;
  logic          gray_req;
  logic [7:0]    gray_data = 8'd0;
  logic          win_valid;
  logic          win_ready = 1'b0;
  logic [71:0]   win_data;
  logic [AW-1:0] win_addr;
  logic          finish;

  always #5 clk = ~clk;

  always @(posedge clk) if (gray_req) gray_data <= 8'(gray_addr);

  lbp_window_sequencer #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .gray_addr (gray_addr),
    .gray_req  (gray_req),
    .gray_data (gray_data),
    .win_valid (win_valid),
    .win_ready (win_ready),
    .win_data  (win_data),
    .win_addr  (win_addr),
    .finish    (finish)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [71:0]   data;
  } win_t;

  win_t          exp_win[$];
  logic [AW-1:0] exp_req[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int n_presented = 0;
  int n_accepted = 0;
  bit seen = 1'b0;
  bit log_req = 1'b0;
  int visited[W*H];

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic win_t mk_win(input int r, input int c);
    win_t w;
    w.addr = AW'(r*W + c);
    w.data = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        w.data[8*(i*3+j) +: 8] = 8'((r-1+i)*W + (c-1+j));
    return w;
  endfunction

  task automatic build_expect();
    exp_win.delete();
    exp_req.delete();
    for (int r = 1; r <= H-2; r++) begin
      for (int c = 1; c <= W-2; c++) begin
        exp_win.push_back(mk_win(r, c));
        if (c == 1) begin
          for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
              exp_req.push_back(AW'((r-1+i)*W + (c-1+j)));
        end else begin
          for (int i = 0; i < 3; i++)
            exp_req.push_back(AW'((r-1+i)*W + c + 1));
        end
      end
    end
  endtask

  task automatic tick();
    bit            hs;
    win_t          e;
    logic [AW-1:0] ea;
    hs = win_valid && win_ready;
    @(posedge clk);
    #1;
    cyc++;
    if (hs) begin
      seen = 1'b0;
      n_accepted++;
    end
    if (log_req && gray_req) begin
      if (exp_req.size() == 0) begin
        chk("req_unexpected", 72'(exp_req.size()), 72'(1));
      end else begin
        ea = exp_req.pop_front();
        chk("req_addr", 72'(gray_addr), 72'(ea));
      end
    end
    if (win_valid && !seen) begin
      seen = 1'b1;
      n_presented++;
      if (exp_win.size() == 0) begin
        chk("win_unexpected", 72'(exp_win.size()), 72'(1));
      end else begin
        e = exp_win.pop_front();
        chk("win_data", win_data, e.data);
        chk("win_addr", 72'(win_addr), 72'(e.addr));
      end
      visited[win_addr]++;
    end
  endtask

  task automatic release_reset();
    repeat (2) @(posedge clk);
    #1;
    reset       = 1'b0;
    cyc         = 0;
    seen        = 1'b0;
    n_presented = 0;
    n_accepted  = 0;
    build_expect();
  endtask

  initial begin
    int          t_fin;
    int          bad;
    logic [71:0] snap_d;
    logic [AW-1:0] snap_a;

    // Reset state
    reset     = 1'b1;
    win_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ctl", 72'({gray_addr, gray_req, win_valid, win_addr, finish}), 72'(0));
    chk("rst_win_data", win_data, 72'(0));

    // Full scan with win_ready=1: windows, request order, finish timing
    for (int a = 0; a < W*H; a++) visited[a] = 0;
    release_reset();
    log_req = 1'b1;
    for (int n = 0; n < 400 && !finish; n++) tick();
    t_fin = finish ? cyc : -1;
    log_req = 1'b0;
    chk("finish_cycle", 72'(t_fin), 72'(217));
    chk("accepted_count", 72'(n_accepted), 72'(36));
    chk("presented_count", 72'(n_presented), 72'(36));
    bad = 0;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        if (visited[r*W+c] != ((r >= 1 && r <= H-2 && c >= 1 && c <= W-2) ? 1 : 0)) bad++;
    chk("interior_once", 72'(bad), 72'(0));
    chk("win_queue_drained", 72'(exp_win.size()), 72'(0));
    chk("req_queue_drained", 72'(exp_req.size()), 72'(0));
    bad = 0;
    repeat (50) begin
      tick();
      if (!finish || gray_req || win_valid) bad++;
    end
    chk("done_sticky", 72'(bad), 72'(0));

    // Back-pressure on window 5
    reset = 1'b1;
    release_reset();
    for (int n = 0; n < 200 && n_presented < 5; n++) tick();
    chk("stall_reached", 72'(n_presented), 72'(5));
    win_ready = 1'b0;
    snap_d = win_data;
    snap_a = win_addr;
    chk("stall_addr", 72'(snap_a), 72'(13));
    bad = 0;
    repeat (20) begin
      tick();
      if (!win_valid || gray_req || win_data !== snap_d || win_addr !== snap_a) bad++;
    end
    chk("stall_stable", 72'(bad), 72'(0));
    chk("stall_no_accept", 72'(n_accepted), 72'(4));
    win_ready = 1'b1;

    // Run on to the SHIFT of window 20, then reset mid-fetch
    for (int n = 0; n < 400 && n_accepted < 19; n++) tick();
    chk("shift20_accepts", 72'(n_accepted), 72'(19));
    chk("shift20_req", 72'(gray_req), 72'(1));
    chk("shift20_addr", 72'(gray_addr), 72'(27));
    reset = 1'b1;
    #1;
    chk("midrst_ctl", 72'({gray_addr, gray_req, win_valid, win_addr, finish}), 72'(0));
    chk("midrst_win_data", win_data, 72'(0));
    release_reset();
    for (int n = 0; n < 5 && !gray_req; n++) tick();
    chk("restart_addr", 72'(gray_addr), 72'(0));
    chk("restart_req_cycle", 72'(cyc), 72'(1));
    for (int n = 0; n < 30 && n_presented < 1; n++) tick();
    chk("restart_win_cycle", 72'(cyc), 72'(11));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
